// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, LSB-first, with 2-flop input synchronizer.
// Produces one-clk rx_done or frame_err pulses per frame; d_out holds the last good byte.
module uart_rx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       baud_rate,
    input  logic       rx,
    output logic [7:0] d_out,
    output logic       rx_done,
    output logic       frame_err
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam logic [2:0] LAST_BIT  = 3'(DBIT - 1);
    localparam logic [3:0] STOP_LAST = 4'(SB_TICK - 1);
    localparam int         ALIGN     = 8 - DBIT;

    state_t     state, state_next;
    logic       rx_meta, rx_s;
    logic [3:0] s, s_next;
    logic [2:0] n, n_next;
    logic [7:0] shreg, shreg_next;
    logic [7:0] d_out_next;
    logic [7:0] rx_byte;
    logic       rx_done_next, frame_err_next;
    logic       armed, armed_next;

    // Synchronizer resets to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            s         <= 4'd0;
            n         <= 3'd0;
            shreg     <= 8'h00;
            d_out     <= 8'h00;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
            armed     <= 1'b0;
        end else begin
            state     <= state_next;
            s         <= s_next;
            n         <= n_next;
            shreg     <= shreg_next;
            d_out     <= d_out_next;
            rx_done   <= rx_done_next;
            frame_err <= frame_err_next;
            armed     <= armed_next;
        end
    end

    // Short frames land in the top bits of the shift register.
    assign rx_byte = shreg >> ALIGN;

    always_comb begin
        state_next     = state;
        s_next         = s;
        n_next         = n;
        shreg_next     = shreg;
        d_out_next     = d_out;
        rx_done_next   = 1'b0;
        frame_err_next = 1'b0;
        armed_next     = armed | rx_s;

        case (state)
            IDLE: begin
                if (armed && !rx_s) begin
                    state_next = START;
                    s_next     = 4'd0;
                end
            end
            START: begin
                if (baud_rate) begin
                    if (s == 4'd7) begin
                        if (!rx_s) begin
                            state_next = DATA;
                            s_next     = 4'd0;
                            n_next     = 3'd0;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        s_next = s + 4'd1;
                    end
                end
            end
            DATA: begin
                if (baud_rate) begin
                    if (s == 4'd15) begin
                        shreg_next = {rx_s, shreg[7:1]};
                        s_next     = 4'd0;
                        if (n == LAST_BIT) begin
                            state_next = STOP;
                        end else begin
                            n_next = n + 3'd1;
                        end
                    end else begin
                        s_next = s + 4'd1;
                    end
                end
            end
            STOP: begin
                if (baud_rate) begin
                    if (s == STOP_LAST) begin
                        state_next = IDLE;
                        if (rx_s) begin
                            d_out_next   = rx_byte;
                            rx_done_next = 1'b1;
                        end else begin
                            // Disarm so a held-low line cannot retrigger a frame.
                            frame_err_next = 1'b1;
                            armed_next     = 1'b0;
                        end
                    end else begin
                        s_next = s + 4'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a behavioural transmitter drives rx on a 16x tick grid
// and each test task checks pulse counts, received bytes and frame timing.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic       baud_rate;
    logic       rx  = 1'b1;
    logic       rx7 = 1'b1;
    logic [7:0] d_out, d_out7;
    logic       rx_done, frame_err, rx_done7, frame_err7;

    int tests_run = 0;
    int failed    = 0;
    int cyc       = 0;
    int tick_num  = 0;
    int start_tick = 0;
    int done_tick  = 0;
    int done_cnt = 0, err_cnt = 0, both_cnt = 0;
    int done7_cnt = 0, err7_cnt = 0;
    logic [7:0] rx_log[$];
    logic use7 = 1'b0;

    always #5 clk = ~clk;

    uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
        .clk(clk), .reset(reset), .baud_rate(baud_rate), .rx(rx),
        .d_out(d_out), .rx_done(rx_done), .frame_err(frame_err)
    );

    uart_rx #(.DBIT(7), .SB_TICK(16)) dut7 (
        .clk(clk), .reset(reset), .baud_rate(baud_rate), .rx(rx7),
        .d_out(d_out7), .rx_done(rx_done7), .frame_err(frame_err7)
    );

    // Baud tick every 4th clk, changed on the falling edge.
    initial begin
        baud_rate = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (cyc % 4 == 0) begin
                baud_rate = 1'b1;
                tick_num++;
            end else begin
                baud_rate = 1'b0;
            end
        end
    end

    // Counts high cycles, so a stretched pulse shows up as an extra count.
    always @(posedge clk) begin
        #1;
        if (rx_done === 1'b1) begin
            done_cnt++;
            done_tick = tick_num;
            rx_log.push_back(d_out);
        end
        if (frame_err === 1'b1) err_cnt++;
        if (rx_done === 1'b1 && frame_err === 1'b1) both_cnt++;
        if (rx_done7 === 1'b1) done7_cnt++;
        if (frame_err7 === 1'b1) err7_cnt++;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic wait_ticks(input int k);
        int c = 0;
        while (c < k) begin
            @(posedge clk);
            if (baud_rate) c++;
        end
        #1;
    endtask

    task automatic drive_line(input logic b);
        if (use7) rx7 = b;
        else      rx  = b;
    endtask

    task automatic send_frame(input logic [7:0] data, input int nbits, input logic stop_bit);
        wait_ticks(1);
        drive_line(1'b0);
        start_tick = tick_num;
        wait_ticks(16);
        for (int i = 0; i < nbits; i++) begin
            drive_line(data[i]);
            wait_ticks(16);
        end
        drive_line(stop_bit);
        wait_ticks(16);
        drive_line(1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rx    = 1'b1;
        rx7   = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        tests_run++;
        if (d_out !== 8'h00) begin
            failed++;
            $display("[TB] FAIL reset_d_out: got %h, expected 00", d_out);
        end
        tests_run++;
        if (rx_done !== 1'b0) begin
            failed++;
            $display("[TB] FAIL reset_rx_done: got %b, expected 0", rx_done);
        end
        tests_run++;
        if (frame_err !== 1'b0) begin
            failed++;
            $display("[TB] FAIL reset_frame_err: got %b, expected 0", frame_err);
        end
        reset = 1'b0;
        wait_ticks(20);
        tests_run++;
        if (done_cnt !== 0 || err_cnt !== 0) begin
            failed++;
            $display("[TB] FAIL reset_idle_quiet: got done=%0d err=%0d, expected 0/0", done_cnt, err_cnt);
        end
    endtask

    task automatic test_single_frame();
        int d0 = done_cnt;
        int e0 = err_cnt;
        send_frame(8'h99, 8, 1'b1);
        wait_ticks(16);
        tests_run++;
        if (done_cnt - d0 !== 1) begin
            failed++;
            $display("[TB] FAIL single_done_count: got %0d, expected 1", done_cnt - d0);
        end
        tests_run++;
        if (d_out !== 8'h99) begin
            failed++;
            $display("[TB] FAIL single_d_out: got %h, expected 99", d_out);
        end
        tests_run++;
        if (err_cnt - e0 !== 0) begin
            failed++;
            $display("[TB] FAIL single_no_err: got %0d, expected 0", err_cnt - e0);
        end
        tests_run++;
        if (done_tick - start_tick !== 152) begin
            failed++;
            $display("[TB] FAIL single_frame_ticks: got %0d, expected 152", done_tick - start_tick);
        end
    endtask

    task automatic test_back_to_back();
        int d0 = done_cnt;
        int q0 = rx_log.size();
        send_frame(8'h99, 8, 1'b1);
        send_frame(8'hDA, 8, 1'b1);
        wait_ticks(16);
        tests_run++;
        if (done_cnt - d0 !== 2) begin
            failed++;
            $display("[TB] FAIL b2b_done_count: got %0d, expected 2", done_cnt - d0);
        end
        tests_run++;
        if (rx_log[q0] !== 8'h99) begin
            failed++;
            $display("[TB] FAIL b2b_first_byte: got %h, expected 99", rx_log[q0]);
        end
        tests_run++;
        if (rx_log[q0+1] !== 8'hDA) begin
            failed++;
            $display("[TB] FAIL b2b_second_byte: got %h, expected da", rx_log[q0+1]);
        end
        tests_run++;
        if (d_out !== 8'hDA) begin
            failed++;
            $display("[TB] FAIL b2b_d_out: got %h, expected da", d_out);
        end
    endtask

    task automatic test_glitch();
        int d0 = done_cnt;
        int e0 = err_cnt;
        wait_ticks(1);
        rx = 1'b0;
        wait_ticks(4);
        rx = 1'b1;
        wait_ticks(40);
        tests_run++;
        if (done_cnt - d0 !== 0 || err_cnt - e0 !== 0) begin
            failed++;
            $display("[TB] FAIL glitch_no_pulse: got done=%0d err=%0d, expected 0/0",
                     done_cnt - d0, err_cnt - e0);
        end
        tests_run++;
        if (d_out !== 8'hDA) begin
            failed++;
            $display("[TB] FAIL glitch_d_out_held: got %h, expected da", d_out);
        end
        send_frame(8'h3C, 8, 1'b1);
        wait_ticks(16);
        tests_run++;
        if (done_cnt - d0 !== 1 || d_out !== 8'h3C) begin
            failed++;
            $display("[TB] FAIL glitch_recover: got done=%0d d_out=%h, expected 1/3c", done_cnt - d0, d_out);
        end
    endtask

    task automatic test_frame_error();
        int d0 = done_cnt;
        int e0 = err_cnt;
        send_frame(8'h55, 8, 1'b0);
        wait_ticks(24);
        tests_run++;
        if (err_cnt - e0 !== 1) begin
            failed++;
            $display("[TB] FAIL ferr_err_count: got %0d, expected 1", err_cnt - e0);
        end
        tests_run++;
        if (done_cnt - d0 !== 0) begin
            failed++;
            $display("[TB] FAIL ferr_no_done: got %0d, expected 0", done_cnt - d0);
        end
        tests_run++;
        if (d_out !== 8'h3C) begin
            failed++;
            $display("[TB] FAIL ferr_d_out_held: got %h, expected 3c", d_out);
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] data = 8'hDA;
        int d0 = done_cnt;
        int e0 = err_cnt;
        wait_ticks(1);
        rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 3; i++) begin
            rx = data[i];
            wait_ticks(16);
        end
        rx = data[3];
        wait_ticks(8);
        rx = 1'b0;
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b0;
        wait_ticks(5);
        rx = 1'b1;
        wait_ticks(40);
        tests_run++;
        if (done_cnt - d0 !== 0 || err_cnt - e0 !== 0) begin
            failed++;
            $display("[TB] FAIL midreset_no_pulse: got done=%0d err=%0d, expected 0/0",
                     done_cnt - d0, err_cnt - e0);
        end
        tests_run++;
        if (d_out !== 8'h00) begin
            failed++;
            $display("[TB] FAIL midreset_d_out: got %h, expected 00", d_out);
        end
        send_frame(8'h99, 8, 1'b1);
        wait_ticks(16);
        tests_run++;
        if (done_cnt - d0 !== 1 || d_out !== 8'h99) begin
            failed++;
            $display("[TB] FAIL midreset_next_frame: got done=%0d d_out=%h, expected 1/99", done_cnt - d0, d_out);
        end
    endtask

    task automatic test_break();
        int d0 = done_cnt;
        int e0 = err_cnt;
        wait_ticks(1);
        rx = 1'b0;
        wait_ticks(300);
        rx = 1'b1;
        wait_ticks(20);
        tests_run++;
        if (err_cnt - e0 !== 1) begin
            failed++;
            $display("[TB] FAIL break_err_count: got %0d, expected 1", err_cnt - e0);
        end
        tests_run++;
        if (done_cnt - d0 !== 0) begin
            failed++;
            $display("[TB] FAIL break_no_done: got %0d, expected 0", done_cnt - d0);
        end
        send_frame(8'hDA, 8, 1'b1);
        wait_ticks(16);
        tests_run++;
        if (done_cnt - d0 !== 1 || d_out !== 8'hDA) begin
            failed++;
            $display("[TB] FAIL break_recover: got done=%0d d_out=%h, expected 1/da", done_cnt - d0, d_out);
        end
        tests_run++;
        if (both_cnt !== 0) begin
            failed++;
            $display("[TB] FAIL pulses_exclusive: got %0d overlaps, expected 0", both_cnt);
        end
    endtask

    task automatic test_dbit7();
        int d0 = done7_cnt;
        int e0 = err7_cnt;
        int m0 = done_cnt;
        use7 = 1'b1;
        send_frame(8'h65, 7, 1'b1);
        wait_ticks(16);
        use7 = 1'b0;
        tests_run++;
        if (done7_cnt - d0 !== 1 || err7_cnt - e0 !== 0) begin
            failed++;
            $display("[TB] FAIL dbit7_pulses: got done=%0d err=%0d, expected 1/0", done7_cnt - d0, err7_cnt - e0);
        end
        tests_run++;
        if (d_out7 !== 8'h65) begin
            failed++;
            $display("[TB] FAIL dbit7_d_out: got %h, expected 65", d_out7);
        end
        tests_run++;
        if (done_cnt - m0 !== 0) begin
            failed++;
            $display("[TB] FAIL dbit7_main_quiet: got %0d, expected 0", done_cnt - m0);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_glitch();
        test_frame_error();
        test_reset_midframe();
        test_break();
        test_dbit7();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
